// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin framer sharing one UART transmitter (sync, payload, inverted checksum)
module uart_tx_sched #(
  parameter int NUM_REQ = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int MAX_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done
);
  localparam int IW = NUM_REQ > 2 ? 2 : 1;
  typedef enum logic [2:0] {IDLE, HDR, HDR_W, PLD, PLD_W, CSUM, CSUM_W} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt, g, g_nxt, pick, pick_lo, pick_hi;
  logic hi_found, busy_nxt, trmt_nxt, last_seen, last_nxt, last_in, done_w, accept;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [7:0] tx_nxt, sum, sum_nxt, cnt, cnt_nxt, byte_in;
  assign req_ready = (state == PLD) ? (grant & req_valid) : '0;
  assign accept = |req_ready;
  // tx_done is still high from the previous byte while trmt is out, so only trust it afterwards
  assign done_w = tx_done & ~trmt;
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    hi_found = 1'b0;
    byte_in = 8'h00;
    last_in = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) pick_lo = IW'(i);
      if (req_valid[i] && IW'(i) >= rr_ptr) begin
        pick_hi = IW'(i);
        hi_found = 1'b1;
      end
      if (IW'(i) == g) begin
        byte_in = req_data[8*i +: 8];
        last_in = req_last[i];
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    busy_nxt = busy;
    trmt_nxt = 1'b0;
    tx_nxt = tx_data;
    sum_nxt = sum;
    cnt_nxt = cnt;
    last_nxt = last_seen;
    rr_nxt = rr_ptr;
    g_nxt = g;
    case (state)
      IDLE: if (|req_valid) begin
        g_nxt = pick;
        for (int i = 0; i < NUM_REQ; i++) grant_nxt[i] = (IW'(i) == pick);
        busy_nxt = 1'b1;
        sum_nxt = 8'h00;
        cnt_nxt = 8'h00;
        last_nxt = 1'b0;
        state_nxt = HDR;
      end
      HDR: begin
        trmt_nxt = 1'b1;
        tx_nxt = SYNC_BYTE;
        state_nxt = HDR_W;
      end
      HDR_W: state_nxt = done_w ? PLD : HDR_W;
      PLD: if (accept) begin
        trmt_nxt = 1'b1;
        tx_nxt = byte_in;
        sum_nxt = sum + byte_in;
        cnt_nxt = cnt + 8'd1;
        last_nxt = last_in | ((cnt + 8'd1) == 8'(MAX_LEN));
        state_nxt = PLD_W;
      end
      PLD_W: state_nxt = done_w ? (last_seen ? CSUM : PLD) : PLD_W;
      CSUM: begin
        trmt_nxt = 1'b1;
        tx_nxt = ~sum;
        state_nxt = CSUM_W;
      end
      CSUM_W: if (done_w) begin
        grant_nxt = '0;
        busy_nxt = 1'b0;
        rr_nxt = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
      trmt <= 1'b0;
      tx_data <= 8'h00;
      sum <= 8'h00;
      cnt <= 8'h00;
      last_seen <= 1'b0;
      rr_ptr <= '0;
      g <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      busy <= busy_nxt;
      trmt <= trmt_nxt;
      tx_data <= tx_nxt;
      sum <= sum_nxt;
      cnt <= cnt_nxt;
      last_seen <= last_nxt;
      rr_ptr <= rr_nxt;
      g <= g_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: frame-level reference model of the scheduler, directed cases plus random traffic
module tb_uart_tx_sched;
  localparam int N = 3;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic busy, trmt, tx_done;
  logic [7:0] tx_data;
  int errors = 0, checks = 0;
  logic [8:0] q [N][$];
  logic [7:0] exp_q[$], log_q[$], exp_lit[$];
  int glog[$], gexp[$];
  bit rnd_mode = 1'b0;
  bit [N-1:0] en = '1;
  int rr_m = 0, cur_g = 0, lat = 0;
  logic [N-1:0] prev_grant = '0, prev_valid = '0, prev_hs = '0, hs_now = '0;
  logic prev_trmt = 1'b0, start_prev = 1'b0;

  uart_tx_sched #(.NUM_REQ(N), .SYNC_BYTE(8'hAA), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input bit l);
    q[r].push_back({l, b});
  endtask

  task automatic cmp_log(input string name);
    chk({name, "_len"}, log_q.size(), exp_lit.size());
    for (int i = 0; i < exp_lit.size() && i < log_q.size(); i++) chk(name, log_q[i], exp_lit[i]);
    log_q.delete();
  endtask

  task automatic cmp_glog(input string name);
    chk({name, "_len"}, glog.size(), gexp.size());
    for (int i = 0; i < gexp.size() && i < glog.size(); i++) chk(name, glog[i], gexp[i]);
    glog.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pend = grant != 0;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) pend = 1'b1;
    end while (pend && n < budget);
    chk("idle_timeout", 32'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  // UART transmitter stand-in: drops tx_done on trmt, raises it after a random byte time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      lat <= 0;
    end else if (trmt) begin
      tx_done <= 1'b0;
      lat <= $urandom_range(1, 6);
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) tx_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_now[i] && q[i].size() > 0) void'(q[i].pop_front());
      req_valid[i] = q[i].size() > 0 && (rnd_mode ? $urandom_range(0, 3) != 0 : en[i]);
      {req_last[i], req_data[8*i +: 8]} = q[i].size() > 0 ? q[i][0] : 9'h000;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [7:0] s;
    logic [8:0] b;
    if (!rst_n) begin
      exp_q.delete();
      rr_m = 0;
      prev_grant = '0;
      prev_valid = '0;
      prev_hs = '0;
      hs_now = '0;
      prev_trmt = 1'b0;
      start_prev = 1'b0;
    end else begin
      hs_now = req_valid & req_ready;
      chk("ready_mask", req_ready & ~(grant & req_valid), 0);
      chk("grant_onehot", $onehot0(grant), 1);
      chk("busy", busy, |grant);
      if (prev_grant != 0 && grant != 0) chk("grant_stable", grant, prev_grant);
      if (prev_grant == 0 && prev_valid != 0) chk("grant_on_req", 32'(grant != 0), 1);
      if (prev_grant == 0 && grant != 0) begin
        g = 0;
        for (int k = 0; k < N; k++) if (prev_valid[(rr_m + k) % N]) begin
          g = (rr_m + k) % N;
          break;
        end
        chk("grant_rr", grant, 1 << g);
        cur_g = g;
        glog.push_back(g);
        exp_q.push_back(8'hAA);
        s = 8'h00;
        for (int n = 0; n < ML && n < q[g].size(); n++) begin
          b = q[g][n];
          exp_q.push_back(b[7:0]);
          s = s + b[7:0];
          if (b[8]) break;
        end
        exp_q.push_back(~s);
      end
      if (prev_grant != 0 && grant == 0) begin
        chk("frame_done", exp_q.size(), 0);
        rr_m = (cur_g + 1) % N;
      end
      if (start_prev) chk("hdr_latency", trmt, 1);
      if (|prev_hs) chk("pld_latency", trmt, 1);
      if (prev_trmt) chk("trmt_width", trmt, 0);
      if (grant == 0) chk("no_trmt_idle", trmt, 0);
      if (trmt) begin
        chk("tx_idle", tx_done, 1);
        if (exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
        else chk("trmt_expected", 0, 1);
        log_q.push_back(tx_data);
      end
      start_prev = prev_grant == 0 && grant != 0;
      prev_grant = grant;
      prev_valid = req_valid;
      prev_hs = hs_now;
      prev_trmt = trmt;
    end
  end

  initial begin
    int n;
    int r, len;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trmt", trmt, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    @(posedge clk);
    push(0, 8'h31, 1); push(0, 8'h32, 1);
    push(1, 8'h41, 1); push(1, 8'h42, 1);
    wait_idle(2000);
    gexp = '{0, 1, 0, 1};
    cmp_glog("contention_order");
    exp_lit = '{8'hAA, 8'h31, 8'hCE, 8'hAA, 8'h41, 8'hBE, 8'hAA, 8'h32, 8'hCD, 8'hAA, 8'h42, 8'hBD};
    cmp_log("contention_bytes");

    @(posedge clk);
    push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 1);
    wait_idle(2000);
    exp_lit = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'hF9};
    cmp_log("single_frame");

    @(posedge clk);
    push(0, 8'hFF, 0); push(0, 8'hFF, 1);
    wait_idle(2000);
    exp_lit = '{8'hAA, 8'hFF, 8'hFF, 8'h01};
    cmp_log("csum_wrap");

    glog.delete();
    @(posedge clk);
    push(1, 8'h10, 0); push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 0); push(1, 8'h14, 1);
    wait_idle(2000);
    exp_lit = '{8'hAA, 8'h10, 8'h11, 8'h12, 8'h13, 8'hB9, 8'hAA, 8'h14, 8'hEB};
    cmp_log("forced_term");
    gexp = '{1, 1};
    cmp_glog("forced_grants");

    @(posedge clk);
    push(0, 8'h21, 0); push(0, 8'h22, 0); push(0, 8'h23, 0); push(0, 8'h24, 1);
    n = 0;
    while (q[0].size() != 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach", 32'(n < 1000), 1);
    en[0] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 490; i++) begin
      @(negedge clk);
      chk("stall_quiet", {busy, trmt}, 2'b10);
    end
    en[0] = 1'b1;
    wait_idle(2000);
    exp_lit = '{8'hAA, 8'h21, 8'h22, 8'h23, 8'h24, 8'h75};
    cmp_log("stall_frame");

    @(posedge clk);
    push(1, 8'h50, 0); push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
    n = 0;
    while (log_q.size() < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", 32'(n < 1000), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    #1;
    chk("arst_trmt", trmt, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    log_q.delete();
    glog.delete();
    @(posedge clk);
    push(0, 8'h61, 1);
    push(1, 8'h71, 1);
    wait_idle(2000);
    gexp = '{0, 1};
    cmp_glog("post_rst_order");
    exp_lit = '{8'hAA, 8'h61, 8'h9E, 8'hAA, 8'h71, 8'h8E};
    cmp_log("post_rst_bytes");

    rnd_mode = 1'b1;
    repeat (80) begin
      @(posedge clk);
      r = $urandom_range(0, N - 1);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) push(r, 8'($urandom), k == len - 1);
      repeat ($urandom_range(0, 15)) @(posedge clk);
    end
    wait_idle(30000);
    chk("rnd_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
